mdu_iterative: RTL and testbench

- Parametrised multi-cycle multiply/divide unit with HI/LO result registers for the MIPS EX stage. It sits beside the single-cycle ALU.
- Executes MULT/MULTU/DIV/DIVU iteratively, one bit per cycle, using a start/busy/done handshake so the pipeline controller can stall dependent MFHI/MFLO.
- Also services MTHI/MTLO.
- Generalises the ALU to configurable width, adds signed/unsigned modes, and adds sequential long-latency behaviour with abort.

---
 rtl/mdu_iterative.sv | 156 +++++++++++++++
 tb/tb_mdu_iterative.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iterative.sv
// mdu_iterative: multi-cycle multiply/divide unit with HI/LO registers.
// Executes MULT/MULTU (shift-add) and DIV/DIVU (restoring) one bit per
// cycle behind a start/busy/done handshake. MTHI/MTLO write HI/LO directly.
// A flush aborts an in-flight operation without touching HI/LO.
module mdu_iterative #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   localparam logic [2:0] OP_MTHI = 3'b100;
   localparam logic [2:0] OP_MTLO = 3'b101;

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t             r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   // Multiply: {partial product, remaining multiplier bits}.
   // Divide:   {partial remainder, dividend bits shifting into quotient}.
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_opnd;      // multiplicand or divisor magnitude
   logic               r_is_div;
   logic               r_neg_q;     // negate product / quotient at the end
   logic               r_neg_r;     // negate remainder at the end
   logic               r_done;
   logic               r_dz;
   logic [WIDTH-1:0]   r_hi, r_lo;

   logic               w_op_ok, w_accept, w_is_div_op, w_signed;
   logic               w_divz, w_iter_start, w_final;
   logic [WIDTH-1:0]   w_mag_a, w_mag_b;
   logic [WIDTH:0]     w_mul_sum;
   logic [WIDTH:0]     w_rem_sh;
   logic [WIDTH-1:0]   w_rem_sub;
   logic               w_ge;
   logic [2*WIDTH-1:0] w_mul_nxt, w_div_nxt, w_step, w_prod;
   logic [WIDTH-1:0]   w_quo, w_rem, w_res_hi, w_res_lo;

   // Request decode: ops 110/111 are reserved and never accepted.
   assign w_op_ok      = (op[2:1] != 2'b11);
   assign w_accept     = start & ~busy & ~flush & w_op_ok;
   assign w_is_div_op  = ~op[2] & op[1];
   assign w_signed     = ~op[2] & ~op[0];
   assign w_divz       = w_is_div_op & (b == '0);
   assign w_iter_start = w_accept & ~op[2] & ~w_divz;
   assign w_final      = (r_state == S_RUN) & ~flush & (r_cnt == CNT_W'(1));

   // Two's-complement magnitudes; -2^(WIDTH-1) maps onto itself as unsigned.
   assign w_mag_a = (w_signed & a[WIDTH-1]) ? -a : a;
   assign w_mag_b = (w_signed & b[WIDTH-1]) ? -b : b;

   // One shift-add multiply step: add multiplicand if LSB set, shift right.
   assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
   assign w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};

   // One restoring divide step: shift in next dividend bit, trial subtract.
   assign w_rem_sh  = r_acc[2*WIDTH-1:WIDTH-1];
   assign w_ge      = (w_rem_sh >= {1'b0, r_opnd});
   assign w_rem_sub = w_rem_sh[WIDTH-1:0] - r_opnd;
   assign w_div_nxt = {(w_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};

   assign w_step = r_is_div ? w_div_nxt : w_mul_nxt;

   // Sign correction applied to the result of the final iteration.
   assign w_prod   = r_neg_q ? -w_step : w_step;
   assign w_quo    = r_neg_q ? -w_step[WIDTH-1:0] : w_step[WIDTH-1:0];
   assign w_rem    = r_neg_r ? -w_step[2*WIDTH-1:WIDTH] : w_step[2*WIDTH-1:WIDTH];
   assign w_res_hi = r_is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
   assign w_res_lo = r_is_div ? w_quo : w_prod[WIDTH-1:0];

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state logic and busy output.
   always_comb begin
      w_state_nxt = r_state;
      busy        = (r_state == S_RUN);
      case (r_state)
         S_IDLE: if (w_iter_start)      w_state_nxt = S_RUN;
         S_RUN:  if (flush || w_final)  w_state_nxt = S_IDLE;
         default:                       w_state_nxt = S_IDLE;
      endcase
   end

   // Datapath: operand latch, iteration, HI/LO write and completion flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt    <= '0;
         r_acc    <= '0;
         r_opnd   <= '0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_done   <= 1'b0;
         r_dz     <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
      end else begin
         r_done <= 1'b0;
         r_dz   <= 1'b0;
         if (w_accept) begin
            if (op == OP_MTHI) begin
               r_hi   <= a;
               r_done <= 1'b1;
            end else if (op == OP_MTLO) begin
               r_lo   <= a;
               r_done <= 1'b1;
            end else if (w_divz) begin
               r_done <= 1'b1;
               r_dz   <= 1'b1;
            end else begin
               r_cnt    <= CNT_W'(WIDTH);
               r_is_div <= w_is_div_op;
               r_opnd   <= w_is_div_op ? w_mag_b : w_mag_a;
               r_acc    <= {{WIDTH{1'b0}}, (w_is_div_op ? w_mag_a : w_mag_b)};
               r_neg_q  <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
               r_neg_r  <= w_signed & a[WIDTH-1];
            end
         end else if (r_state == S_RUN) begin
            if (flush) begin
               r_cnt <= '0;
            end else begin
               r_acc <= w_step;
               r_cnt <= r_cnt - CNT_W'(1);
               if (w_final) begin
                  r_hi   <= w_res_hi;
                  r_lo   <= w_res_lo;
                  r_done <= 1'b1;
               end
            end
         end
      end
   end

   assign done     = r_done;
   assign div_zero = r_dz;
   assign hi       = r_hi;
   assign lo       = r_lo;

endmodule

// File: tb/tb_mdu_iterative.sv
// tb_mdu_iterative: directed + random checks of mdu_iterative at WIDTH=32
// and WIDTH=8 against an arithmetic reference model.
module tb_mdu_iterative;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, flush, s32, s8;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic        busy32, done32, dz32, busy8, done8, dz8;
   logic [31:0] hi32, lo32;
   logic [7:0]  hi8, lo8;

   int n_chk = 0;
   int n_err = 0;
   longint unsigned exp_hi[2];
   longint unsigned exp_lo[2];

   mdu_iterative #(.WIDTH(32)) u32 (
      .clk(clk), .rst(rst), .start(s32), .op(op), .a(a), .b(b), .flush(flush),
      .busy(busy32), .done(done32), .div_zero(dz32), .hi(hi32), .lo(lo32));

   mdu_iterative #(.WIDTH(8)) u8 (
      .clk(clk), .rst(rst), .start(s8), .op(op), .a(a[7:0]), .b(b[7:0]), .flush(flush),
      .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8));

   function automatic logic o_busy(bit w8); return w8 ? busy8 : busy32; endfunction
   function automatic logic o_done(bit w8); return w8 ? done8 : done32; endfunction
   function automatic logic o_dz(bit w8);   return w8 ? dz8 : dz32;     endfunction
   function automatic logic [31:0] o_hi(bit w8); return w8 ? {24'b0, hi8} : hi32; endfunction
   function automatic logic [31:0] o_lo(bit w8); return w8 ? {24'b0, lo8} : lo32; endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic on sign-extended operands.
   task automatic model(input int w, input logic [2:0] o, input logic [31:0] av,
                        input logic [31:0] bv, inout longint unsigned eh,
                        inout longint unsigned el, output bit dz);
      longint unsigned mask, ua, ub, up;
      longint sa, sb, p, q, r;
      mask = (64'd1 << w) - 1;
      ua = av & mask;
      ub = bv & mask;
      sa = ((ua >> (w - 1)) & 1) != 0 ? longint'(ua) - (longint'(1) << w) : longint'(ua);
      sb = ((ub >> (w - 1)) & 1) != 0 ? longint'(ub) - (longint'(1) << w) : longint'(ub);
      dz = 1'b0;
      case (o)
         3'd0: begin p = sa * sb; eh = ($unsigned(p) >> w) & mask; el = $unsigned(p) & mask; end
         3'd1: begin up = ua * ub; eh = (up >> w) & mask; el = up & mask; end
         3'd2: if (ub == 0) dz = 1'b1;
               else begin q = sa / sb; r = sa % sb; eh = $unsigned(r) & mask; el = $unsigned(q) & mask; end
         3'd3: if (ub == 0) dz = 1'b1;
               else begin eh = (ua % ub) & mask; el = (ua / ub) & mask; end
         3'd4: eh = ua;
         3'd5: el = ua;
         default: ;
      endcase
   endtask

   // Issue one accepted operation and follow it to completion.
   task automatic run_op(input bit w8, input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
      int w, n;
      bit dz;
      longint unsigned ph, pl, th, tl;
      w  = w8 ? 8 : 32;
      ph = exp_hi[w8];
      pl = exp_lo[w8];
      th = ph;
      tl = pl;
      model(w, o, av, bv, th, tl, dz);
      exp_hi[w8] = th;
      exp_lo[w8] = tl;
      op = o; a = av; b = bv;
      if (w8) s8 = 1'b1; else s32 = 1'b1;
      tick();
      s8 = 1'b0; s32 = 1'b0;
      a = $urandom; b = $urandom; op = 3'($urandom_range(0, 5));
      if (o >= 3'd4 || dz) begin
         chk("imm_done", o_done(w8), 1'b1);
         chk("imm_busy", o_busy(w8), 1'b0);
         chk("imm_dz", o_dz(w8), dz);
         chk("imm_hi", o_hi(w8), exp_hi[w8]);
         chk("imm_lo", o_lo(w8), exp_lo[w8]);
         tick();
         chk("imm_done_pulse", o_done(w8), 1'b0);
         return;
      end
      chk("acc_busy", o_busy(w8), 1'b1);
      chk("acc_done", o_done(w8), 1'b0);
      chk("hold_hi", o_hi(w8), ph);
      chk("hold_lo", o_lo(w8), pl);
      n = 0;
      while (!o_done(w8) && n < 100) begin
         tick();
         n++;
      end
      chk("latency", n, w);
      chk("end_busy", o_busy(w8), 1'b0);
      chk("end_dz", o_dz(w8), 1'b0);
      chk("res_hi", o_hi(w8), exp_hi[w8]);
      chk("res_lo", o_lo(w8), exp_lo[w8]);
      tick();
      chk("done_pulse", o_done(w8), 1'b0);
   endtask

   initial begin
      int n;
      bit seen;
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      longint unsigned th, tl;
      bit dz;
      rst = 1'b1; flush = 1'b0; s32 = 1'b0; s8 = 1'b0; op = '0; a = '0; b = '0;
      exp_hi[0] = 0; exp_lo[0] = 0; exp_hi[1] = 0; exp_lo[1] = 0;
      tick(); tick();
      rst = 1'b0;
      tick();
      chk("rst_busy", busy32, 1'b0);
      chk("rst_done", done32, 1'b0);
      chk("rst_dz", dz32, 1'b0);
      chk("rst_hi", hi32, 32'h0);
      chk("rst_lo", lo32, 32'h0);

      // Directed arithmetic cases with hard-coded answers.
      run_op(1'b0, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      chk("multu_max_hi", hi32, 32'hFFFF_FFFE);
      chk("multu_max_lo", lo32, 32'h0000_0001);
      run_op(1'b0, 3'd0, 32'hFFFF_FFF9, 32'd6);
      chk("mult_neg_hi", hi32, 32'hFFFF_FFFF);
      chk("mult_neg_lo", lo32, 32'hFFFF_FFD6);
      run_op(1'b0, 3'd2, 32'hFFFF_FFF9, 32'd2);
      chk("div_neg_lo", lo32, 32'hFFFF_FFFD);
      chk("div_neg_hi", hi32, 32'hFFFF_FFFF);
      run_op(1'b0, 3'd3, 32'd100, 32'd0);
      chk("divz_hi_kept", hi32, 32'hFFFF_FFFF);
      chk("divz_lo_kept", lo32, 32'hFFFF_FFFD);
      run_op(1'b0, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      chk("div_ovf_lo", lo32, 32'h8000_0000);
      chk("div_ovf_hi", hi32, 32'h0);

      // Random operations, including occasional zero and small divisors.
      for (int i = 0; i < 24; i++) begin
         ro = 3'($urandom_range(0, 5));
         ra = $urandom;
         rb = ($urandom_range(0, 7) == 0) ? 32'h0 :
              ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 15)) : 32'($urandom);
         if ($urandom_range(0, 3) == 0) ra = -ra;
         run_op(1'b0, ro, ra, rb);
      end

      // Flush mid-multiply: no done, HI/LO untouched.
      op = 3'd1; a = 32'd3; b = 32'd5; s32 = 1'b1;
      tick();
      s32 = 1'b0;
      repeat (9) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_busy", busy32, 1'b0);
      chk("flush_done", done32, 1'b0);
      seen = 1'b0;
      repeat (40) begin tick(); if (done32) seen = 1'b1; end
      chk("flush_no_done", seen, 1'b0);
      chk("flush_hi", hi32, exp_hi[0]);
      chk("flush_lo", lo32, exp_lo[0]);

      // Start while busy is ignored; original operation completes normally.
      ra = $urandom; rb = $urandom;
      th = exp_hi[0]; tl = exp_lo[0];
      model(32, 3'd1, ra, rb, th, tl, dz);
      op = 3'd1; a = ra; b = rb; s32 = 1'b1;
      tick();
      s32 = 1'b0;
      repeat (3) tick();
      op = 3'd4; a = 32'hDEAD_BEEF; s32 = 1'b1;
      tick();
      s32 = 1'b0;
      n = 4;
      while (!done32 && n < 100) begin tick(); n++; end
      exp_hi[0] = th; exp_lo[0] = tl;
      chk("busy_start_latency", n, 32);
      chk("busy_start_hi", hi32, exp_hi[0]);
      chk("busy_start_lo", lo32, exp_lo[0]);
      tick();
      chk("busy_start_no_done", done32, 1'b0);

      // Flush coinciding with the completing edge wins.
      op = 3'd1; a = $urandom; b = $urandom; s32 = 1'b1;
      tick();
      s32 = 1'b0;
      repeat (31) tick();
      chk("pre_final_busy", busy32, 1'b1);
      chk("pre_final_done", done32, 1'b0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("final_flush_done", done32, 1'b0);
      chk("final_flush_busy", busy32, 1'b0);
      chk("final_flush_hi", hi32, exp_hi[0]);
      chk("final_flush_lo", lo32, exp_lo[0]);
      tick();
      chk("final_flush_done2", done32, 1'b0);
      run_op(1'b0, 3'd0, $urandom, $urandom);

      // Back-to-back MTHI/MTLO.
      op = 3'd4; a = 32'h1234_5678; s32 = 1'b1;
      tick();
      op = 3'd5; a = 32'hCAFE_0000;
      chk("mthi_done", done32, 1'b1);
      chk("mthi_busy", busy32, 1'b0);
      chk("mthi_hi", hi32, 32'h1234_5678);
      tick();
      s32 = 1'b0;
      chk("mtlo_done", done32, 1'b1);
      chk("mtlo_busy", busy32, 1'b0);
      chk("mtlo_lo", lo32, 32'hCAFE_0000);
      chk("mtlo_hi", hi32, 32'h1234_5678);
      exp_hi[0] = 64'h1234_5678; exp_lo[0] = 64'hCAFE_0000;
      tick();
      chk("mtlo_pulse", done32, 1'b0);

      // Reserved ops and start-with-flush are ignored.
      op = 3'd6; a = 32'h5555_5555; s32 = 1'b1;
      tick();
      chk("rsv6_done", done32, 1'b0);
      op = 3'd7;
      tick();
      chk("rsv7_done", done32, 1'b0);
      chk("rsv_busy", busy32, 1'b0);
      op = 3'd4; flush = 1'b1;
      tick();
      s32 = 1'b0; flush = 1'b0;
      chk("flush_start_done", done32, 1'b0);
      chk("ign_hi", hi32, exp_hi[0]);
      chk("ign_lo", lo32, exp_lo[0]);

      // Reset during a divide.
      op = 3'd3; a = $urandom; b = 32'd7; s32 = 1'b1;
      tick();
      s32 = 1'b0;
      repeat (4) tick();
      rst = 1'b1;
      tick();
      chk("midrst_busy", busy32, 1'b0);
      chk("midrst_done", done32, 1'b0);
      chk("midrst_hi", hi32, 32'h0);
      chk("midrst_lo", lo32, 32'h0);
      rst = 1'b0;
      exp_hi[0] = 0; exp_lo[0] = 0; exp_hi[1] = 0; exp_lo[1] = 0;
      seen = 1'b0;
      repeat (36) begin tick(); if (done32) seen = 1'b1; end
      chk("midrst_no_done", seen, 1'b0);

      // WIDTH=8 instance.
      run_op(1'b1, 3'd1, 32'hFF, 32'hFF);
      chk("w8_multu_hi", hi8, 8'hFE);
      chk("w8_multu_lo", lo8, 8'h01);
      run_op(1'b1, 3'd2, 32'h80, 32'hFF);
      chk("w8_div_ovf_lo", lo8, 8'h80);
      chk("w8_div_ovf_hi", hi8, 8'h00);
      for (int i = 0; i < 16; i++) begin
         ro = 3'($urandom_range(0, 5));
         ra = $urandom;
         rb = ($urandom_range(0, 5) == 0) ? 32'h0 : 32'($urandom);
         run_op(1'b1, ro, ra, rb);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
